// File: rtl/key_click_gen.sv
// key_click_gen: emulates a push button for a single/long/double-click
// decoder. A command is accepted over a valid/ready handshake. The block then
// drives an active-low key line through PRESS1 [GAP PRESS2] RECOVER with
// exact phase lengths. Optional deterministic contact bounce can be added at
// the start of every phase.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   cmd_valid  command present (source holds it until cmd_ready)
//   cmd_type   00 single, 01 long, 10 double, 11 reserved
//   cmd_ready  high only while idle
//   key_out    emulated key, idle high, pressed low
//   busy       inverse of cmd_ready
//   done       one-cycle pulse in the last recover cycle
//   cmd_err    one-cycle pulse after a reserved type is accepted
module key_click_gen #(
    parameter int T_PRESS    = 4800000,
    parameter int T_LONG     = 72000000,
    parameter int T_GAP      = 1200000,
    parameter int T_RECOVER  = 7200000,
    parameter int BOUNCE_N   = 0,
    parameter int BOUNCE_CYC = 24000,
    parameter int CW         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_type,
    output logic       cmd_ready,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);

    typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, RECOVER} state_t;

    localparam logic [1:0] TYPE_LONG   = 2'b01;
    localparam logic [1:0] TYPE_DOUBLE = 2'b10;
    localparam logic [1:0] TYPE_RSVD   = 2'b11;

    localparam logic [CW-1:0] PRESS_LAST = CW'(T_PRESS - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
    localparam logic [CW-1:0] REC_LAST   = CW'(T_RECOVER - 1);

    // Bounce: seg counts cycles inside a segment, tog counts finished
    // segments and parks at TOG_END once the bounce window is over.
    localparam int TW = $clog2(2 * BOUNCE_N + 2);
    localparam int SW = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
    localparam logic [TW-1:0] TOG_END  = TW'(2 * BOUNCE_N);
    localparam logic [SW-1:0] SEG_LAST = SW'(BOUNCE_CYC - 1);

    localparam int MIN_PG  = (T_PRESS < T_GAP) ? T_PRESS : T_GAP;
    localparam int MIN_ALL = (MIN_PG < T_RECOVER) ? MIN_PG : T_RECOVER;
    localparam bit PARAM_OK = (T_PRESS >= 1) && (T_LONG >= 1) && (T_GAP >= 1) &&
                              (T_RECOVER >= 1) && (2 * BOUNCE_N * BOUNCE_CYC < MIN_ALL) &&
                              (64'(T_LONG) < (64'd1 << CW)) &&
                              (64'(T_RECOVER) < (64'd1 << CW));

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      type_q, type_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic [TW-1:0]   tog_q, tog_d;
    logic            key_q, key_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            last;
    logic [CW-1:0]   last_val;
    logic            target;

    assign accept = cmd_valid && ready_q;

    // State register (all flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            seg_q   <= '0;
            tog_q   <= '0;
            key_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            seg_q   <= seg_d;
            tog_q   <= tog_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (PARAM_OK);
    end

    // Next-state and phase counters.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        last_val = PRESS_LAST;
        case (state_q)
            PRESS1:  last_val = (type_q == TYPE_LONG) ? LONG_LAST : PRESS_LAST;
            GAP:     last_val = GAP_LAST;
            PRESS2:  last_val = PRESS_LAST;
            RECOVER: last_val = REC_LAST;
            default: last_val = PRESS_LAST;
        endcase
        last = (cnt_q == last_val);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    type_d = cmd_type;
                    if (cmd_type != TYPE_RSVD) state_d = PRESS1;
                end
            end
            PRESS1:  if (last) state_d = (type_q == TYPE_DOUBLE) ? GAP : RECOVER;
            GAP:     if (last) state_d = PRESS2;
            PRESS2:  if (last) state_d = RECOVER;
            RECOVER: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every transition is a phase entry; IDLE keeps the counters cleared.
        cnt_d = '0;
        seg_d = '0;
        tog_d = '0;
        if (state_d != state_q || state_d == IDLE) begin
            cnt_d = '0;
            seg_d = '0;
            tog_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            seg_d = seg_q;
            tog_d = tog_q;
            if (tog_q != TOG_END) begin
                if (seg_q == SEG_LAST) begin
                    seg_d = '0;
                    tog_d = tog_q + 1'b1;
                end else begin
                    seg_d = seg_q + 1'b1;
                end
            end
        end
    end

    // Outputs, computed from next-state values so they register in step.
    always_comb begin
        target  = !(state_d == PRESS1 || state_d == PRESS2);
        // Odd segments inside the bounce window invert the target level.
        key_d   = target ^ ((tog_d != TOG_END) && tog_d[0]);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == RECOVER) && (cnt_d == REC_LAST);
        err_d   = accept && (state_q == IDLE) && (cmd_type == TYPE_RSVD);
    end

    assign cmd_ready = ready_q;
    assign key_out   = key_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_key_click_gen.sv
module tb_key_click_gen;

    logic       clk = 1'b0;
    logic       rst, cmd_valid;
    logic [1:0] cmd_type;
    logic       cmd_ready, key_out, busy, done, cmd_err;

    logic       b_rst, b_valid;
    logic [1:0] b_type;
    logic       b_ready, b_key, b_busy, b_done, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_click_gen #(.T_PRESS(4), .T_LONG(20), .T_GAP(3), .T_RECOVER(6),
                    .BOUNCE_N(0), .BOUNCE_CYC(1), .CW(8)) u_clean (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_ready(cmd_ready), .key_out(key_out), .busy(busy), .done(done),
        .cmd_err(cmd_err));

    key_click_gen #(.T_PRESS(4), .T_LONG(20), .T_GAP(3), .T_RECOVER(6),
                    .BOUNCE_N(1), .BOUNCE_CYC(1), .CW(8)) u_bounce (
        .clk(clk), .rst(b_rst), .cmd_valid(b_valid), .cmd_type(b_type),
        .cmd_ready(b_ready), .key_out(b_key), .busy(b_busy), .done(b_done),
        .cmd_err(b_err));

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] t;
        logic       k;
        logic       rd;
        logic       d;
        logic       e;
    } vec_t;

    vec_t vq[$];

    task automatic seg(input int n, input logic r, input logic v, input logic [1:0] t,
                       input logic k, input logic rd, input logic d, input logic e);
        vec_t x;
        x.r = r; x.v = v; x.t = t; x.k = k; x.rd = rd; x.d = d; x.e = e;
        repeat (n) vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int step, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %b required %b", nm, step, act, exp);
        end
    endtask

    task automatic run_b(input logic [1:0] t, input int n, input logic [31:0] pat, input int base);
        b_valid = 1'b1;
        b_type  = t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            b_valid = 1'b0;
            chk("bounce_key", base + i, b_key, pat[i]);
            chk("bounce_done", base + i, b_done, (i == n - 1));
            chk("bounce_ready", base + i, b_ready, 1'b0);
        end
        @(posedge clk); #1;
        chk("bounce_ready_back", base + n, b_ready, 1'b1);
        chk("bounce_done_clear", base + n, b_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00;
        b_rst = 1'b1; b_valid = 1'b0; b_type = 2'b00;

        //  n  rst vld typ  key rdy done err
        seg(2, 1, 0, 2'd0, 1, 1, 0, 0);   // reset
        seg(1, 0, 0, 2'd0, 1, 1, 0, 0);
        // single
        seg(1, 0, 1, 2'd0, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(5, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(1, 0, 0, 2'd0, 1, 0, 1, 0);
        // double presented while still busy: ignored, then taken next edge
        seg(1, 0, 1, 2'd2, 1, 1, 0, 0);
        seg(1, 0, 1, 2'd2, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(4, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(5, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(1, 0, 0, 2'd0, 1, 0, 1, 0);
        seg(1, 0, 0, 2'd0, 1, 1, 0, 0);
        // reserved
        seg(1, 0, 1, 2'd3, 1, 1, 0, 1);
        seg(1, 0, 0, 2'd0, 1, 1, 0, 0);
        // long
        seg(1, 0, 1, 2'd1, 0, 0, 0, 0);
        seg(19, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(5, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(1, 0, 0, 2'd0, 1, 0, 1, 0);
        seg(1, 0, 0, 2'd0, 1, 1, 0, 0);
        // reserved, then single taken during the error pulse cycle
        seg(1, 0, 1, 2'd3, 1, 1, 0, 1);
        seg(1, 0, 1, 2'd0, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(5, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(1, 0, 0, 2'd0, 1, 0, 1, 0);
        seg(1, 0, 0, 2'd0, 1, 1, 0, 0);
        // reset during PRESS2 of a double
        seg(1, 0, 1, 2'd2, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(2, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(1, 1, 0, 2'd0, 1, 1, 0, 0);
        seg(2, 0, 0, 2'd0, 1, 1, 0, 0);
        seg(1, 0, 1, 2'd0, 0, 0, 0, 0);
        seg(3, 0, 0, 2'd0, 0, 0, 0, 0);
        seg(5, 0, 0, 2'd0, 1, 0, 0, 0);
        seg(1, 0, 0, 2'd0, 1, 0, 1, 0);
        seg(1, 0, 0, 2'd0, 1, 1, 0, 0);

        foreach (vq[i]) begin
            rst       = vq[i].r;
            cmd_valid = vq[i].v;
            cmd_type  = vq[i].t;
            @(posedge clk); #1;
            chk("key_out", i, key_out, vq[i].k);
            chk("cmd_ready", i, cmd_ready, vq[i].rd);
            chk("busy", i, busy, ~vq[i].rd);
            chk("done", i, done, vq[i].d);
            chk("cmd_err", i, cmd_err, vq[i].e);
        end
        cmd_valid = 1'b0;

        // Bounce instance: reset, then a single and a double.
        @(posedge clk); #1;
        b_rst = 1'b0;
        chk("bounce_reset_key", 0, b_key, 1'b1);
        chk("bounce_reset_ready", 0, b_ready, 1'b1);
        // single: press 0,1,0,0 then recover 1,0,1,1,1,1
        run_b(2'd0, 10, 32'b1111010010, 100);
        // double: 0100 101 0100 101111
        run_b(2'd2, 17, 32'b11110100101010010, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
